// File: rtl/add_sub_serial.sv
// add_sub_serial: multi-cycle adder/subtractor that sums CHUNK bits per clock
// with a rippled carry register, optional signed saturation and a zero flag.
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high; the producer holds its beat steady until that edge, and the consumer
// may raise ready at any time.
module add_sub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_p,
  input  logic [WIDTH-1:0]   in_q,
  input  logic               mode,
  input  logic               sat_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_s,
  output logic               out_c,
  output logic               out_o,
  output logic               out_z,
  output logic [1:0]         dbgState
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // Refuse to elaborate with a chunk size that does not tile the operand.
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : gBadParams
    $error("add_sub_serial: WIDTH must be a positive multiple of CHUNK");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] pReg;
  logic [WIDTH-1:0] qReg;      // Q already inverted for subtraction
  logic             modeReg;
  logic             satReg;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] accReg;    // partial result built chunk by chunk
  logic [WIDTH-1:0] sReg;
  logic             cReg;
  logic             oReg;
  logic             zReg;

  logic [CHUNK-1:0] pSlice;
  logic [CHUNK-1:0] qSlice;
  logic [CHUNK-1:0] chunkSum;
  logic             chunkCo;
  logic             msbCin;
  logic             ovf;
  logic             lastChunk;
  logic [WIDTH-1:0] fullSum;
  logic [WIDTH-1:0] satVal;
  logic [WIDTH-1:0] finalSum;

  // Current chunk sum, overflow detection and the saturated candidate result.
  always_comb begin
    pSlice    = pReg[idx*CHUNK +: CHUNK];
    qSlice    = qReg[idx*CHUNK +: CHUNK];
    {chunkCo, chunkSum} = {1'b0, pSlice} + {1'b0, qSlice} + {{CHUNK{1'b0}}, carry};
    // Carry into the chunk's top bit recovered from its sum and operand bits.
    msbCin    = chunkSum[CHUNK-1] ^ pSlice[CHUNK-1] ^ qSlice[CHUNK-1];
    ovf       = msbCin ^ chunkCo;
    lastChunk = (idx == IDXW'(NCHUNK - 1));
    fullSum   = accReg;
    fullSum[idx*CHUNK +: CHUNK] = chunkSum;
    satVal    = pReg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    finalSum  = (satReg && ovf) ? satVal : fullSum;
  end

  // Operation sequencer: accept operands, ripple through chunks, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pReg    <= '0;
      qReg    <= '0;
      modeReg <= 1'b0;
      satReg  <= 1'b0;
      carry   <= 1'b0;
      idx     <= '0;
      accReg  <= '0;
      sReg    <= '0;
      cReg    <= 1'b0;
      oReg    <= 1'b0;
      zReg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pReg    <= in_p;
            qReg    <= in_q ^ {WIDTH{mode}};
            modeReg <= mode;
            satReg  <= sat_en;
            carry   <= mode;
            idx     <= '0;
            accReg  <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          accReg <= fullSum;
          carry  <= chunkCo;
          idx    <= idx + 1'b1;
          if (lastChunk) begin
            sReg  <= finalSum;
            cReg  <= chunkCo ^ modeReg;
            oReg  <= ovf;
            zReg  <= (finalSum == '0);
            state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == HOLD);
  assign out_s     = {{WIDTH{1'b0}}, sReg};
  assign out_c     = cReg;
  assign out_o     = oReg;
  assign out_z     = zReg;
  assign dbgState  = state;

endmodule

// File: tb/tb_add_sub_serial.sv
// tb_add_sub_serial: drives three configurations of add_sub_serial
// (16/4, 8/8, 32/4) and compares every result against an arithmetic model.
module tb_add_sub_serial;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  inValid  = '0;
  logic [2:0]  outReady = '0;
  logic [31:0] inP = '0;
  logic [31:0] inQ = '0;
  logic        mode = 1'b0;
  logic        satEn = 1'b0;

  wire [2:0]  inReady, outValid, outC, outO, outZ;
  wire [31:0] outS16;
  wire [15:0] outS8;
  wire [63:0] outS32;
  wire [1:0]  dbg16, dbg8, dbg32;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  logic [63:0] expQ[$];

  add_sub_serial #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_p(inP[15:0]), .in_q(inQ[15:0]), .mode(mode), .sat_en(satEn),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_s(outS16),
    .out_c(outC[0]), .out_o(outO[0]), .out_z(outZ[0]), .dbgState(dbg16));

  add_sub_serial #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_p(inP[7:0]), .in_q(inQ[7:0]), .mode(mode), .sat_en(satEn),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_s(outS8),
    .out_c(outC[1]), .out_o(outO[1]), .out_z(outZ[1]), .dbgState(dbg8));

  add_sub_serial #(.WIDTH(32), .CHUNK(4)) dut32 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .in_p(inP), .in_q(inQ), .mode(mode), .sat_en(satEn),
    .out_valid(outValid[2]), .out_ready(outReady[2]), .out_s(outS32),
    .out_c(outC[2]), .out_o(outO[2]), .out_z(outZ[2]), .dbgState(dbg32));

  // ---------------- helpers ----------------
  function automatic int widthOf(input int sel);
    case (sel)
      0: return 16;
      1: return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int latencyOf(input int sel);
    case (sel)
      0: return 4;
      1: return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] readS(input int sel);
    case (sel)
      0: return {32'b0, outS16};
      1: return {48'b0, outS8};
      default: return outS32;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: exact signed arithmetic, then wrap or clamp.
  task automatic refModel(input int w, input logic [31:0] p, input logic [31:0] q,
                          input logic md, input logic sat,
                          output logic [63:0] s, output logic c, output logic o,
                          output logic z);
    longint mask, up, uq, sp, sq, exact, maxV, minV, r;
    mask  = (64'sd1 <<< w) - 1;
    up    = longint'(p) & mask;
    uq    = longint'(q) & mask;
    sp    = (up >= (64'sd1 <<< (w-1))) ? up - (64'sd1 <<< w) : up;
    sq    = (uq >= (64'sd1 <<< (w-1))) ? uq - (64'sd1 <<< w) : uq;
    exact = md ? sp - sq : sp + sq;
    maxV  = (64'sd1 <<< (w-1)) - 1;
    minV  = -(64'sd1 <<< (w-1));
    o     = (exact > maxV) || (exact < minV);
    c     = md ? (up < uq) : (((up + uq) >>> w) != 0);
    r     = (o && sat) ? ((exact > maxV) ? maxV : minV) : exact;
    s     = 64'(r & mask);
    z     = (s == 64'd0);
  endtask

  // ---------------- driver task ----------------
  task automatic runOp(input int sel, input logic [31:0] p, input logic [31:0] q,
                       input logic md, input logic sat, input int holdCyc);
    logic [63:0] es, expS;
    logic ec, eo, ez;
    int lat;
    int n;
    n = latencyOf(sel);
    refModel(widthOf(sel), p, q, md, sat, es, ec, eo, ez);
    @(negedge clk);
    inP = p; inQ = q; mode = md; satEn = sat; inValid[sel] = 1'b1;
    #1 check("in_ready_idle", 64'(inReady[sel]), 64'd1);
    @(posedge clk);
    expQ.push_back(es);
    #1;
    inValid[sel] = 1'b0;
    // Operands change after the accept edge; the result must not care.
    inP = $urandom; inQ = $urandom; mode = 1'($urandom); satEn = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= n + 4 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (outValid[sel]) lat = i;
    end
    check("latency", 64'(lat), 64'(n));
    expS = (expQ.size() > 0) ? expQ.pop_front() : 64'hDEAD;
    check("out_s", readS(sel), expS);
    check("out_c", 64'(outC[sel]), 64'(ec));
    check("out_o", 64'(outO[sel]), 64'(eo));
    check("out_z", 64'(outZ[sel]), 64'(ez));
    check("in_ready_hold", 64'(inReady[sel]), 64'd0);
    for (int i = 0; i < holdCyc; i++) begin
      inValid[sel] = 1'b1;   // must be ignored while a result is pending
      @(posedge clk);
      #1;
      check("hold_valid", 64'(outValid[sel]), 64'd1);
      check("hold_s", readS(sel), expS);
      check("hold_flags", {61'b0, outC[sel], outO[sel], outZ[sel]}, {61'b0, ec, eo, ez});
      check("hold_in_ready", 64'(inReady[sel]), 64'd0);
    end
    inValid[sel]  = 1'b0;
    outReady[sel] = 1'b1;
    @(posedge clk);
    #1;
    outReady[sel] = 1'b0;
    check("valid_drop", 64'(outValid[sel]), 64'd0);
    check("in_ready_after", 64'(inReady[sel]), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] maxP, minP, rp, rq;
    int w;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 64'(inReady), 64'd0);
    check("rst_out_valid", 64'(outValid), 64'd0);
    check("rst_out_s", {32'b0, outS16}, 64'd0);
    check("rst_flags", 64'({outC, outO, outZ}), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1 check("rel_in_ready", 64'(inReady), 64'd7);

    // Directed cases on each configuration
    for (int sel = 0; sel < 3; sel++) begin
      w    = widthOf(sel);
      maxP = 32'((64'd1 << (w-1)) - 1);
      minP = 32'(64'd1 << (w-1));
      runOp(sel, 32'd245, 32'd127, 1'b0, 1'b0, 1);
      runOp(sel, 32'd245, 32'd127, 1'b1, 1'b0, 0);
      runOp(sel, 32'd0, 32'd1, 1'b1, 1'b0, 0);
      runOp(sel, maxP, 32'd1, 1'b0, 1'b0, 0);
      runOp(sel, maxP, 32'd1, 1'b0, 1'b1, 0);
      runOp(sel, minP, 32'd1, 1'b1, 1'b1, 0);
      runOp(sel, 32'h1234, 32'h1234, 1'b1, 1'b0, 5);
    end

    // Reset in the middle of an operation (16/4, chunk index 2)
    runOp(0, 32'd245, 32'd127, 1'b0, 1'b0, 0);
    @(negedge clk);
    inP = 32'd100; inQ = 32'd23; mode = 1'b0; satEn = 1'b0; inValid[0] = 1'b1;
    @(posedge clk);
    #1 inValid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    check("abort_out_valid", 64'(outValid), 64'd0);
    check("abort_out_s", {32'b0, outS16}, 64'd0);
    check("abort_flags", 64'({outC, outO, outZ}), 64'd0);
    check("abort_in_ready", 64'(inReady), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_result", 64'(outValid), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    runOp(0, 32'h7000, 32'h0FFF, 1'b0, 1'b0, 0);

    // Randomized operations with boundary-biased operands
    for (int sel = 0; sel < 3; sel++) begin
      w = widthOf(sel);
      for (int k = 0; k < 25; k++) begin
        case ($urandom_range(0, 4))
          0: rp = 32'((64'd1 << (w-1)) - 1);
          1: rp = 32'(64'd1 << (w-1));
          2: rp = 32'd0;
          default: rp = $urandom;
        endcase
        rq = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        runOp(sel, rp, rq, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
